// File: rtl/sram_bist_pkg.sv
// Shared types and per-element March C- tables for the SRAM BIST.
package sram_bist_pkg;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } march_elem_e;

    typedef enum logic {
        OP_R = 1'b0,
        OP_W = 1'b1
    } op_e;

    // M3 and M4 walk the array from the top address down.
    function automatic logic elem_down(march_elem_e e);
        return (e == M3) || (e == M4);
    endfunction

    function automatic logic elem_two_ops(march_elem_e e);
        return (e != M0) && (e != M5);
    endfunction

    function automatic logic elem_rd_inv(march_elem_e e);
        return (e == M2) || (e == M4);
    endfunction

    function automatic logic elem_wr_inv(march_elem_e e);
        return (e == M1) || (e == M3);
    endfunction

    // Every element starts with a read except M0; the second op is always a write.
    function automatic op_e elem_op(march_elem_e e, logic second);
        if (second || e == M0) return OP_W;
        return OP_R;
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter with terminal-address flag.
module sram_bist_addr_gen #(
    parameter int NUM_WORDS  = 1024,
    parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  load_down,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(NUM_WORDS - 1);

    logic down;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            down <= 1'b0;
        end else if (load) begin
            addr <= load_down ? TOP : '0;
            down <= load_down;
        end else if (step) begin
            addr <= down ? addr - 1'b1 : addr + 1'b1;
        end
    end

    // Terminal address stops the walk, so out-of-range addresses never appear.
    assign last = down ? (addr == '0) : (addr == TOP);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST initiator: sequences SRAM ops, checks read data, reports results.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    NUM_WORDS  = 1024,
    parameter logic [DATA_WIDTH-1:0] BACKGROUND = '0,
    localparam int                   ADDR_WIDTH = $clog2(NUM_WORDS),
    localparam int                   BE_WIDTH   = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [15:0]           err_cnt_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic [2:0]            fail_elem_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state;
    march_elem_e           elem;
    march_elem_e           next_elem;
    logic                  second;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  addr_last;
    logic                  run, is_rd, is_wr, op_last, elem_end;
    logic                  gen_load, gen_load_down, gen_step;

    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] rd_exp;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]            rd_elem;
    logic                  mismatch;
    logic [15:0]           err_nxt;

    assign run       = (state == S_RUN);
    assign is_wr     = run && (elem_op(elem, second) == OP_W);
    assign is_rd     = run && (elem_op(elem, second) == OP_R);
    assign op_last   = second || !elem_two_ops(elem);
    assign elem_end  = run && op_last && addr_last;
    assign next_elem = march_elem_e'(elem + 3'd1);

    // Element change reloads the counter so the next element starts on the very next cycle.
    assign gen_load      = ((state == S_IDLE) && start_i) || (elem_end && (elem != M5));
    assign gen_load_down = (state == S_IDLE) ? 1'b0 : elem_down(next_elem);
    assign gen_step      = run && op_last && !addr_last;

    sram_bist_addr_gen #(
        .NUM_WORDS (NUM_WORDS),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (gen_load),
        .load_down(gen_load_down),
        .step     (gen_step),
        .addr     (addr),
        .last     (addr_last)
    );

    assign mem_req_o   = run;
    assign mem_we_o    = is_wr;
    assign mem_addr_o  = run ? addr : '0;
    assign mem_be_o    = {BE_WIDTH{run}};
    assign mem_wdata_o = is_wr ? (elem_wr_inv(elem) ? ~BACKGROUND : BACKGROUND) : '0;

    assign busy_o = run || (state == S_CHECK);
    assign done_o = (state == S_DONE);

    assign mismatch = rd_vld && (mem_rdata_i != rd_exp);
    assign err_nxt  = (mismatch && (err_cnt_o != 16'hFFFF)) ? err_cnt_o + 16'd1 : err_cnt_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            elem        <= M0;
            second      <= 1'b0;
            rd_vld      <= 1'b0;
            rd_exp      <= '0;
            rd_addr     <= '0;
            rd_elem     <= '0;
            err_cnt_o   <= '0;
            fail_addr_o <= '0;
            fail_elem_o <= '0;
            fail_data_o <= '0;
            pass_o      <= 1'b0;
        end else begin
            // Read data returns a cycle later, so the expectation rides one stage behind.
            rd_vld <= is_rd;
            if (is_rd) begin
                rd_exp  <= elem_rd_inv(elem) ? ~BACKGROUND : BACKGROUND;
                rd_addr <= addr;
                rd_elem <= elem;
            end
            if (mismatch) begin
                err_cnt_o <= err_nxt;
                if (err_cnt_o == '0) begin
                    fail_addr_o <= rd_addr;
                    fail_elem_o <= rd_elem;
                    fail_data_o <= mem_rdata_i;
                end
            end
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state       <= S_RUN;
                        elem        <= M0;
                        second      <= 1'b0;
                        err_cnt_o   <= '0;
                        fail_addr_o <= '0;
                        fail_elem_o <= '0;
                        fail_data_o <= '0;
                        pass_o      <= 1'b0;
                    end
                end
                S_RUN: begin
                    second <= !op_last;
                    if (elem_end) begin
                        if (elem == M5) state <= S_CHECK;
                        else            elem  <= next_elem;
                    end
                end
                S_CHECK: begin
                    state  <= S_DONE;
                    pass_o <= (err_nxt == '0);
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sram_march_bist.md
Name: sram_march_bist

Overview:
- Built-in self-test initiator that drives the req/we/addr/wdata/be interface of the single-port SRAM model (sp_sram) and checks its read data.
- Runs a March C- sequence over the whole array and reports pass/fail, the first failing address, element and data, and a saturating error count.
- Sits between the SoC control registers (start/status) and the SRAM port, muxed with the functional bus outside this block.

Parameters:
- DATA_WIDTH, 64, SRAM word width in bits.
- NUM_WORDS, 1024, SRAM depth; ADDR_WIDTH = $clog2(NUM_WORDS).
- BACKGROUND, '0 (DATA_WIDTH bits), data background; "0" pattern = BACKGROUND, "1" pattern = ~BACKGROUND.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- busy_o  out  1  test in progress.
- done_o  out  1  one-cycle pulse at test completion.
- pass_o  out  1  last test result; 1 only if zero mismatches.
- err_cnt_o  out  16  mismatch count, saturates at 16'hFFFF.
- fail_addr_o  out  ADDR_WIDTH  address of first mismatch.
- fail_elem_o  out  3  march element (0..5) of first mismatch.
- fail_data_o  out  DATA_WIDTH  read data at first mismatch.
- mem_req_o  out  1  SRAM request.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  ADDR_WIDTH  SRAM address.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_be_o  out  (DATA_WIDTH+7)/8  byte enables; all ones whenever mem_req_o=1.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data; valid the cycle after a read request.

Behaviour:
- Interface: one clock (clk_i); reset is synchronous and active-high (rst_i).
- Reset values: all outputs 0 (mem_be_o 0, pass_o 0, err_cnt_o 0, fail_* 0). Reset is synchronous, so mid-test reset drops mem_req_o on the next edge; state goes to IDLE; no partial results are kept.
- Element sequence: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0).
- Addressing: "up" runs 0..NUM_WORDS-1 and "down" runs NUM_WORDS-1..0.
- Issue rate: one SRAM operation per cycle, no bubbles. In an r,w element, the read and the write to the same address occupy consecutive cycles, then the address steps.
- Total request cycles: 10*NUM_WORDS.
- FSM states: IDLE -> RUN (element/op/address sequencing) -> CHECK (compare of final M5 read, mem_req_o=0) -> DONE (one cycle) -> IDLE.
- Start: start_i=1 in IDLE moves the FSM to RUN at the next edge. The first request (M0, w, addr 0) appears in that RUN cycle.
- Start side effects: err_cnt_o, fail_* and pass_o are cleared on the accepting edge.
- start_i outside IDLE is ignored.
- busy_o is 1 in RUN and CHECK, i.e. exactly 10*NUM_WORDS+1 cycles.
- done_o is 1 only in DONE. pass_o is updated at entry to DONE to (err_cnt==0) and held until the next start or reset.
- Compare pipeline: each read registers expected data, address and element. Comparison happens the following cycle against mem_rdata_i, so reads may be back-to-back (M5).
- On mismatch: err_cnt increments, saturating. If this is the first mismatch, fail_addr/elem/data are captured.
- Address wrap: the address counter never wraps. An element ends when the terminal address (NUM_WORDS-1 up, 0 down) finishes its last op. The next element starts at its own start address on the next cycle.
- Non-power-of-two NUM_WORDS is supported; addresses >= NUM_WORDS are never issued.
- During writes mem_wdata_o holds the pattern; during reads and when idle it is 0.

Decomposition:
- sram_bist_pkg holds:
  - march_elem_e (M0..M5);
  - op_e (OP_R, OP_W);
  - per-element constant tables: direction, op count, read-expect polarity, write polarity.
- Sub-module sram_bist_addr_gen: loadable up/down counter with a terminal-count flag, parameterised on NUM_WORDS.

Test Plan (NUM_WORDS=8, DATA_WIDTH=32, BACKGROUND=0, bench instantiates sp_sram with rst_ni=~rst_i):
- Clean run: start_i pulse -> busy_o high 81 cycles, done_o one pulse, pass_o=1, err_cnt_o=0.
- Stuck-at-1 on bit 3 of word 5 (bench forces it) -> pass_o=0, err_cnt_o=3 (M1, M3, M5 r0), fail_addr_o=5, fail_elem_o=1, fail_data_o=32'h8.
- Sequence check:
  - cycles 1..8: req=1, we=1, addr 0..7, wdata=0;
  - M3: addr pairs 7,7,6,6..0,0 with we 0,1;
  - M5: 8 consecutive reads, addr 0..7.
- start_i held high throughout -> second test begins the cycle after DONE; start pulses during busy have no effect on cycle count.
- rst_i asserted mid-M2 -> next cycle mem_req_o=0, busy_o=0, pass_o=0, err_cnt_o=0; a fresh start then passes.
- Injected error every read at word 0 (bench corrupts rdata, all reads) -> err_cnt_o=5 (one per read element), fail_elem_o=1, fail_addr_o=0.
